pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised inter-stage pipeline register for the pipelined MIPS core, replacing the fixed-field EX/MEM-style latches. Carries a control bundle and a data bundle between stages with a valid/ready handshake, stall back-pressure, synchronous flush that inserts bubbles, and an optional skid buffer to break the combinational ready path. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage widths.

## Interface
- CTRL_W, 4: control-bit width (RegWrite, MemToReg, MemWrite, JAL, …); all-zero is a bubble
- DATA_W, 101: data bundle width (e.g. AluOut 32 + RtD 32 + PCPlus4 32 + WriteReg 5)
- CNT_W, 16: width of the bubble counter
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all held and incoming beats this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage accepts the beat this cycle
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  beat held for downstream
- out_ready  in  1  downstream consumes the beat (0 = stall)
- out_ctrl  out  CTRL_W  control bits; forced 0 whenever out_valid=0
- out_data  out  DATA_W  data bundle
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Main register loads on a transfer in; out_valid clears on a transfer out with no transfer in.
- Bubble rule: any register slot with valid=0 holds ctrl=0, so downstream write enables never fire on a bubble. Data of an empty slot holds its last value (don't care).
- Flush (highest priority after reset): all valid bits and ctrl cleared at the next edge; a beat handshaken in the flush cycle is consumed and discarded; data registers untouched.
- Simultaneous transfer in and out: new beat replaces old; out_valid stays 1.
- bubble_cnt: +1 every cycle out_valid=0 and reset=0; saturates at all-ones; cleared only by reset.

## Timing
- Latency: 1 cycle from transfer in to out_valid with that beat.
- Throughput: 1 beat/cycle while out_ready=1.
- Reset: out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0, skid empty; in_ready=0 while reset is high, 1 the first cycle after.
- Reset mid-stream: all in-flight beats dropped, no partial state retained.
- Without skid: in_ready = ~reset & (~out_valid | out_ready), combinational from out_ready.
- With skid: in_ready is a registered ~skid_valid; never depends combinationally on out_ready.

## Configuration
- PIPE_STAGE_SKID_EN defined: 2-entry arrangement (main + skid). If a beat arrives while main is full and out_ready=0, it goes to skid; in_ready drops next cycle. On the next transfer out, skid moves to main and in_ready returns to 1. Output order strictly FIFO; no beat lost or duplicated. Flush empties both entries.
- Undefined: single register, combinational in_ready as above; skid logic and its registers absent.

## Structure
- Package pipe_pkg: CTRL bit index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMWRITE=2, CTRL_JAL=3), default CTRL_W/DATA_W per stage, bubble constant (all-zero ctrl).
- One sub-module pipe_skid_buf (one-entry holding register with valid), instantiated only under PIPE_STAGE_SKID_EN.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1, in_ctrl=4'b1111 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0; bubble_cnt=0 on release, 1 a cycle later.
- Streaming: out_ready=1, 8 back-to-back beats data=1..8 -> same sequence on out_data, one cycle late, no gaps.
- Stall: out_ready=0 for 3 cycles with beat data=0xA5 held -> out_data=0xA5, out_valid=1 constant; skid build holds a second beat 0x5A, in_ready=0 after it; release -> 0xA5 then 0x5A.
- Flush: beat ctrl=4'b0101 held, flush=1 with new in_valid beat -> next cycle out_valid=0, out_ctrl=0; neither beat ever appears at output.
- Simultaneous in/out: full stage, out_ready=1 and in_valid=1 data=0x33 -> next cycle out_data=0x33, out_valid=1.
- Saturation: CNT_W=4, idle 20 cycles after reset -> bubble_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers: control-bit
// positions, per-stage bundle widths and the bubble encoding.
package pipe_pkg;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_JAL      = 3;

   localparam int PIPE_CTRL_W = 4;
   localparam int PIPE_CNT_W  = 16;

   // Instr + PCPlus4 / RD1 + RD2 + SignImm + PCPlus4 + Rs + Rt + Rd /
   // AluOut + RtD + PCPlus4 + WriteReg / ReadData + AluOut + PCPlus4 + WriteReg
   localparam int IFID_DATA_W  = 64;
   localparam int IDEX_DATA_W  = 143;
   localparam int EXMEM_DATA_W = 101;
   localparam int MEMWB_DATA_W = 101;

   localparam logic [PIPE_CTRL_W-1:0] CTRL_BUBBLE = {PIPE_CTRL_W{1'b0}};

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry holding register with valid, used as the overflow slot of
// pipe_stage when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf #(
   parameter int CTRL_W = 4,
   parameter int DATA_W = 101
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_flush,
   input  logic              i_load,
   input  logic              i_unload,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   // Empty entry keeps ctrl at zero so a stale beat can never look live
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_ctrl  <= {CTRL_W{1'b0}};
         r_data  <= {DATA_W{1'b0}};
      end else if (i_flush) begin
         r_valid <= 1'b0;
         r_ctrl  <= {CTRL_W{1'b0}};
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_ctrl  <= i_ctrl;
         r_data  <= i_data;
      end else if (i_unload) begin
         r_valid <= 1'b0;
         r_ctrl  <= {CTRL_W{1'b0}};
      end
   end

   assign o_valid = r_valid;
   assign o_ctrl  = r_ctrl;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with flush-to-bubble and a saturating bubble
// counter. Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int DATA_W = EXMEM_DATA_W,
   parameter int CNT_W  = PIPE_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic              w_xfer_in;
   logic              w_xfer_out;
   logic              w_main_load;
   logic              w_main_clr;
   logic [CTRL_W-1:0] w_load_ctrl;
   logic [DATA_W-1:0] w_load_data;

   logic              r_main_valid;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic [CNT_W-1:0]  r_bubble_cnt;

   assign w_xfer_in  = in_valid & in_ready;
   assign w_xfer_out = r_main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              w_skid_valid;
   logic [CTRL_W-1:0] w_skid_ctrl;
   logic [DATA_W-1:0] w_skid_data;
   logic              w_skid_load;
   logic              w_skid_unload;

   // skid_valid is a register, so out_ready never reaches in_ready
   assign in_ready = ~reset & ~w_skid_valid;

   // Main/skid steering: a held skid beat always refills main first
   always_comb begin
      w_main_load   = 1'b0;
      w_main_clr    = 1'b0;
      w_load_ctrl   = in_ctrl;
      w_load_data   = in_data;
      w_skid_load   = 1'b0;
      w_skid_unload = 1'b0;
      if (w_xfer_out) begin
         if (w_skid_valid) begin
            w_main_load   = 1'b1;
            w_load_ctrl   = w_skid_ctrl;
            w_load_data   = w_skid_data;
            w_skid_unload = 1'b1;
         end else if (w_xfer_in) begin
            w_main_load = 1'b1;
         end else begin
            w_main_clr = 1'b1;
         end
      end else if (w_xfer_in) begin
         if (r_main_valid) begin
            w_skid_load = 1'b1;
         end else begin
            w_main_load = 1'b1;
         end
      end else begin
         w_main_load = 1'b0;
      end
   end

   pipe_skid_buf #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .i_flush  (flush),
      .i_load   (w_skid_load),
      .i_unload (w_skid_unload),
      .i_ctrl   (in_ctrl),
      .i_data   (in_data),
      .o_valid  (w_skid_valid),
      .o_ctrl   (w_skid_ctrl),
      .o_data   (w_skid_data)
   );
`else
   assign in_ready = ~reset & (~r_main_valid | out_ready);

   // Single register: a new beat wins over draining the old one
   always_comb begin
      w_main_load = 1'b0;
      w_main_clr  = 1'b0;
      w_load_ctrl = in_ctrl;
      w_load_data = in_data;
      if (w_xfer_in) begin
         w_main_load = 1'b1;
      end else if (w_xfer_out) begin
         w_main_clr = 1'b1;
      end else begin
         w_main_clr = 1'b0;
      end
   end
`endif

   // Main output register; flush and drain leave data untouched
   always_ff @(posedge clk) begin
      if (reset) begin
         r_main_valid <= 1'b0;
         r_main_ctrl  <= CTRL_BUBBLE[0] ? {CTRL_W{1'b1}} : {CTRL_W{1'b0}};
         r_main_data  <= {DATA_W{1'b0}};
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_main_ctrl  <= {CTRL_W{1'b0}};
      end else if (w_main_load) begin
         r_main_valid <= 1'b1;
         r_main_ctrl  <= w_load_ctrl;
         r_main_data  <= w_load_data;
      end else if (w_main_clr) begin
         r_main_valid <= 1'b0;
         r_main_ctrl  <= {CTRL_W{1'b0}};
      end
   end

   // Saturating count of empty output cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bubble_cnt <= {CNT_W{1'b0}};
      end else if (!r_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
         r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign out_valid  = r_main_valid;
   assign out_ctrl   = r_main_ctrl;
   assign out_data   = r_main_data;
   assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: the driver queues each accepted beat, a
// monitor pops and compares on every output transfer.
module tb_pipe_stage;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   in_ctrl = 4'h0;
   logic [100:0] in_data = 101'h0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [3:0]   out_ctrl;
   logic [100:0] out_data;
   logic [3:0]   bubble_cnt;

   logic [104:0] exp_q[$];
   int total = 0;
   int bad = 0;
   logic acc;

   always #5 clk = ~clk;

   pipe_stage #(.CTRL_W(4), .DATA_W(101), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl),
      .out_data   (out_data),
      .bubble_cnt (bubble_cnt)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, want);
      end
   endtask

   // one cycle of stimulus; inputs change on negedge, acceptance seen 1ns later
   task automatic drive(input logic rst, input logic v, input logic [3:0] c,
                        input logic [100:0] d, input logic ordy, input logic fl);
      @(negedge clk);
      reset = rst; in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
      #1;
      if (fl) exp_q.delete();
      else if (v && in_ready) exp_q.push_back({c, d});
   endtask

   always @(negedge clk) begin
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat got=%0h want=none", {out_ctrl, out_data});
         end else begin
            logic [104:0] e;
            e = exp_q.pop_front();
            if ({out_ctrl, out_data} !== e) begin
               bad++;
               $display("FAIL beat got=%0h want=%0h", {out_ctrl, out_data}, e);
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      // reset with an upstream beat presented
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 4'hF, 101'h1234, 1'b0, 1'b0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_ctrl", out_ctrl, 0);
         chk("rst_out_data", out_data, 0);
      end
      drive(1'b0, 1'b0, 4'h0, 101'h0, 1'b0, 1'b0);
      chk("rel_bubble_cnt", bubble_cnt, 0);
      chk("rel_in_ready", in_ready, 1);
      // idle 20 cycles: counter saturates at 15
      for (int k = 1; k <= 20; k++) begin
         drive(1'b0, 1'b0, 4'h0, 101'h0, 1'b0, 1'b0);
         chk("bubble_cnt", bubble_cnt, (k > 15) ? 15 : k);
      end

      // streaming 1..8
      for (int k = 1; k <= 8; k++) begin
         drive(1'b0, 1'b1, 4'h1, 101'(k), 1'b1, 1'b0);
         if (k >= 2) chk("stream_valid", out_valid, 1);
      end
      drive(1'b0, 1'b0, 4'h0, 101'h0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 4'h0, 101'h0, 1'b1, 1'b0);

      // stall with a second beat waiting upstream
      drive(1'b0, 1'b1, 4'h3, 101'hA5, 1'b1, 1'b0);
      acc = 1'b0;
      for (int s = 0; s < 3; s++) begin
         drive(1'b0, ~acc, 4'h6, 101'h5A, 1'b0, 1'b0);
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, 101'hA5);
`ifdef PIPE_STAGE_SKID_EN
         chk("stall_in_ready", in_ready, (s == 0) ? 1 : 0);
`else
         chk("stall_in_ready", in_ready, 0);
`endif
         if (in_valid && in_ready) acc = 1'b1;
      end
      for (int s = 0; s < 4; s++) begin
         drive(1'b0, ~acc, 4'h6, 101'h5A, 1'b1, 1'b0);
         if (in_valid && in_ready) acc = 1'b1;
      end

      // flush discards held and incoming beats
      drive(1'b0, 1'b1, 4'h5, 101'h77, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 4'hF, 101'h99, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 4'h0, 101'h0, 1'b1, 1'b0);
      chk("flush_valid", out_valid, 0);
      chk("flush_ctrl", out_ctrl, 0);
      drive(1'b0, 1'b0, 4'h0, 101'h0, 1'b1, 1'b0);
      chk("flush_valid2", out_valid, 0);

      // simultaneous in/out on a full stage
      drive(1'b0, 1'b1, 4'h1, 101'h11, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 4'h2, 101'h33, 1'b1, 1'b0);
      chk("simul_in_ready", in_ready, 1);
      drive(1'b0, 1'b0, 4'h0, 101'h0, 1'b0, 1'b0);
      chk("simul_valid", out_valid, 1);
      chk("simul_data", out_data, 101'h33);
      chk("simul_ctrl", out_ctrl, 4'h2);

      // bounded drain
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         drive(1'b0, 1'b0, 4'h0, 101'h0, 1'b1, 1'b0);
      end
      drive(1'b0, 1'b0, 4'h0, 101'h0, 1'b1, 1'b0);
      chk("queue_empty", 128'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
